// File: rtl/iob_rom_streamer.sv
// iob_rom_streamer
//   Read sequencer for one port of a synchronous ROM. A start command issues
//   a burst of consecutive reads from start_addr_i. The addresses wrap modulo
//   2**ADDR_W. The words are presented on a valid/ready stream with full
//   backpressure support.
//
//   Optional feature: define IOB_ROM_STREAMER_LAST_EN to add last_o, which
//   marks the final word of the burst.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 start pulse, sampled only in IDLE
//   start_addr_i, len_i     first address; word count (0 = no-op)
//   busy_o, done_o          burst in progress; one-cycle completion pulse
//   rom_r_en_o, rom_addr_o  ROM read request
//   rom_r_data_i            ROM data, valid one cycle after rom_r_en_o
//   data_o, valid_o, ready_i  output stream
//   last_o                  final-word marker (only with the macro)
module iob_rom_streamer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W:0]   len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rom_r_en_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_r_data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
`ifdef IOB_ROM_STREAMER_LAST_EN
  output logic              last_o,
`endif
  input  logic              ready_i
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;     // next address to read
  logic [ADDR_W-1:0]   r_addr_q;   // last issued address, held on the port
  logic [ADDR_W:0]     r_rem;      // reads still to issue
  logic                r_inflight; // ROM word arrives on rom_r_data_i this cycle
  logic [DATA_W-1:0]   r_mem [2];
  logic                r_rd, r_wr;
  logic [1:0]          r_cnt;

  logic [1:0] w_out;
  logic       w_issue, w_valid, w_xfer, w_push, w_pop, w_fin;

  // Words owed downstream: buffered plus the one on the ROM bus.
  assign w_out   = r_cnt + {1'b0, r_inflight};
  assign w_issue = (r_state == S_RUN) && (r_rem != '0) && (w_out < 2'd2);

  // The returning ROM word bypasses the empty FIFO. This gives the
  // two-cycle first-word latency. If that word is not taken, it is
  // pushed into the FIFO, so the FIFO head is the oldest word.
  assign w_valid = (r_cnt != 2'd0) || r_inflight;
  assign w_xfer  = w_valid && ready_i;
  assign w_pop   = w_xfer && (r_cnt != 2'd0);
  assign w_push  = r_inflight && !(w_xfer && (r_cnt == 2'd0));
  assign w_fin   = w_xfer && (r_rem == '0) && (w_out == 2'd1);

  assign valid_o    = w_valid;
  assign data_o     = (r_cnt != 2'd0) ? r_mem[r_rd] :
                      (r_inflight ? rom_r_data_i : '0);
  assign rom_r_en_o = w_issue;
  assign rom_addr_o = w_issue ? r_addr : r_addr_q;
  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = (r_state == S_DONE);
`ifdef IOB_ROM_STREAMER_LAST_EN
  assign last_o     = w_valid && (r_rem == '0) && (w_out == 2'd1);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_addr_q   <= '0;
      r_rem      <= '0;
      r_inflight <= 1'b0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_cnt      <= 2'd0;
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start_i) begin
          if (len_i != '0) begin
            r_addr  <= start_addr_i;
            r_rem   <= len_i;
            r_state <= S_RUN;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            r_addr   <= r_addr + ADDR_W'(1);
            r_addr_q <= r_addr;
            r_rem    <= r_rem - (ADDR_W+1)'(1);
          end
          if (w_fin) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase

      r_inflight <= w_issue;
      if (w_push) begin
        r_mem[r_wr] <= rom_r_data_i;
        r_wr        <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_rom_streamer.sv
// Bench for iob_rom_streamer. The ROM holds word[i] = i+32. Expected words
// and read addresses are queued when a burst starts. A negedge monitor
// compares them against what the DUT presents.
module tb_iob_rom_streamer;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic [3:0] start_addr_i = '0;
  logic [4:0] len_i = '0;
  logic       busy_o, done_o, rom_r_en_o, valid_o;
  logic [3:0] rom_addr_o;
  logic [7:0] rom_r_data_i = '0;
  logic [7:0] data_o;
  logic       ready_i = 1'b1;
`ifdef IOB_ROM_STREAMER_LAST_EN
  logic       last_o;
`endif

  iob_rom_streamer #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .start_addr_i(start_addr_i),
    .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .rom_r_en_o(rom_r_en_o),
    .rom_addr_o(rom_addr_o), .rom_r_data_i(rom_r_data_i), .data_o(data_o),
    .valid_o(valid_o),
`ifdef IOB_ROM_STREAMER_LAST_EN
    .last_o(last_o),
`endif
    .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model.
  logic [7:0] rom [16];
  initial for (int i = 0; i < 16; i++) rom[i] = 8'(i + 32);
  always @(posedge clk) if (rom_r_en_o) rom_r_data_i <= rom[rom_addr_o];

  typedef struct packed { logic [7:0] d; logic l; } exp_t;
  exp_t       exp_q [$];
  logic [3:0] addr_q [$];
  int checks = 0, errors = 0;
  int iss = 0, xfr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++; errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Backpressure pattern 1,0,0,1,0,1 repeated.
  int pat [6] = '{1, 0, 0, 1, 0, 1};
  int bp_idx = 0;
  bit bp_mode = 1'b0;
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      ready_i = (pat[bp_idx] != 0);
      bp_idx  = (bp_idx + 1) % 6;
    end else begin
      ready_i = 1'b1;
      bp_idx  = 0;
    end
  end

  // Monitor.
  bit         prev_hold = 0, prev_done = 0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst_i) begin
      prev_hold = 0;
      prev_done = 0;
    end else begin
      if (prev_done) check("done_one_cycle", {31'd0, done_o}, 32'd0);
      if (prev_hold) begin
        check("hold_valid", {31'd0, valid_o}, 32'd1);
        check("hold_data", {24'd0, data_o}, {24'd0, prev_data});
      end
      if (rom_r_en_o) begin
        check("issue_limit", {31'd0, (iss - xfr) < 2}, 32'd1);
        if (addr_q.size() == 0) fail_now("unexpected_rom_read");
        else check("rom_addr", {28'd0, rom_addr_o}, {28'd0, addr_q.pop_front()});
        iss++;
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) fail_now("unexpected_word");
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data", {24'd0, data_o}, {24'd0, e.d});
`ifdef IOB_ROM_STREAMER_LAST_EN
          check("last", {31'd0, last_o}, {31'd0, e.l});
`endif
        end
        xfr++;
      end
      prev_hold = valid_o && !ready_i;
      prev_data = data_o;
      prev_done = done_o;
    end
  end

  // Queue expectations and present the start command. The task returns at
  // the accepting edge T plus 1 time unit.
  task automatic start_burst(input logic [3:0] a, input logic [4:0] n);
    for (int i = 0; i < int'(n); i++) begin
      exp_t e;
      e.d = 8'(((int'(a) + i) % 16) + 32);
      e.l = (i == int'(n) - 1);
      exp_q.push_back(e);
      addr_q.push_back(4'((int'(a) + i) % 16));
    end
    @(posedge clk); #1;
    start_i = 1'b1; start_addr_i = a; len_i = n;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Count the cycles after the accepting edge until done_o is seen.
  task automatic wait_done(input int k0, output int k, output bit ok);
    k = k0; ok = 0;
    while (1) begin
      @(negedge clk);
      k++;
      if (done_o) begin ok = 1; break; end
      if (k > 400) begin fail_now("done_timeout"); break; end
    end
  endtask

  task automatic finish_burst(input bit ok, input string tag);
    if (ok) begin
      check({tag, "_busy_in_done"}, {31'd0, busy_o}, 32'd1);
      @(negedge clk);
      check({tag, "_done_low"}, {31'd0, done_o}, 32'd0);
      check({tag, "_busy_low"}, {31'd0, busy_o}, 32'd0);
    end
    check({tag, "_words_left"}, exp_q.size(), 32'd0);
    check({tag, "_reads_left"}, addr_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k; bit ok;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_en", {31'd0, rom_r_en_o}, 32'd0);
    check("rst_addr", {28'd0, rom_addr_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_data", {24'd0, data_o}, 32'd0);
    @(posedge clk); #1; rst_i = 1'b0;

    // Basic 16-word burst: the first read is at T+1, the first word at T+2,
    // and done_o is at T+18.
    start_burst(4'd0, 5'd16);
    @(negedge clk);
    check("lat_en_t1", {31'd0, rom_r_en_o}, 32'd1);
    check("lat_valid_t1", {31'd0, valid_o}, 32'd0);
    @(negedge clk);
    check("lat_valid_t2", {31'd0, valid_o}, 32'd1);
    check("lat_data_t2", {24'd0, data_o}, 32'h20);
    wait_done(2, k, ok);
    check("basic_done_cycle", k, 32'd18);
    finish_burst(ok, "basic");

    // Wrap from 14.
    start_burst(4'd14, 5'd4);
    wait_done(0, k, ok);
    check("wrap_done_cycle", k, 32'd6);
    finish_burst(ok, "wrap");

    // Backpressure.
    bp_mode = 1'b1;
    start_burst(4'd0, 5'd6);
    wait_done(0, k, ok);
    finish_burst(ok, "bp");
    bp_mode = 1'b0;
    @(posedge clk); #1;

    // Zero length.
    start_burst(4'd3, 5'd0);
    wait_done(0, k, ok);
    check("zero_done_cycle", k, 32'd1);
    finish_burst(ok, "zero");

    // A start pulse mid-burst is ignored.
    start_burst(4'd2, 5'd5);
    start_i = 1'b1; start_addr_i = 4'd9; len_i = 5'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done(0, k, ok);
    finish_burst(ok, "ignore");
    repeat (4) @(posedge clk); #1;

    // Reset after 3 of 8 words, then a fresh burst.
    start_burst(4'd0, 5'd8);
    k = 0;
    while (xfr < 3 && k < 100) begin @(posedge clk); #1; k++; end
    if (xfr < 3) fail_now("reset_wait_timeout");
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    exp_q.delete(); addr_q.delete(); iss = 0; xfr = 0;
    @(negedge clk);
    check("rstmid_valid", {31'd0, valid_o}, 32'd0);
    check("rstmid_busy", {31'd0, busy_o}, 32'd0);
    check("rstmid_en", {31'd0, rom_r_en_o}, 32'd0);
    start_burst(4'd5, 5'd2);
    wait_done(0, k, ok);
    check("rstmid_done_cycle", k, 32'd4);
    finish_burst(ok, "rstmid");

    // Short burst; the monitor checks last_o when it is present.
    start_burst(4'd0, 5'd3);
    wait_done(0, k, ok);
    check("len3_done_cycle", k, 32'd5);
    finish_burst(ok, "len3");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
